// File: rtl/descheduler_block.sv
// Rebuilds four parallel channels from a round-robin serialized word stream.
// The last slot's word bypasses staging, so a frame appears one clock after its final word.
module descheduler_block #(
  parameter int DATA_WIDTH = 16,
  parameter int N_INPUTS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] r0,
  output logic [DATA_WIDTH-1:0] r1,
  output logic [DATA_WIDTH-1:0] r2,
  output logic [DATA_WIDTH-1:0] r3,
  output logic                  frame_valid,
  output logic [1:0]            slot
);

  localparam logic [1:0] LAST_SLOT = 2'(N_INPUTS - 1);

  logic [1:0]            slot_reg;
  logic [DATA_WIDTH-1:0] stage_reg [0:N_INPUTS-2];
  logic [DATA_WIDTH-1:0] frame_reg [0:N_INPUTS-1];
  logic                  frame_valid_reg;
  logic                  capture_last;

  assign capture_last = en && (slot_reg == LAST_SLOT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_reg <= 2'd0;
    end else if (en) begin
      slot_reg <= slot_reg + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_INPUTS - 1; i++) begin
        stage_reg[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < N_INPUTS - 1; i++) begin
        if (slot_reg == 2'(i)) begin
          stage_reg[i] <= data_in;
        end
      end
    end
  end

  // All four outputs move together on one edge so a frame is never seen half-updated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        frame_reg[i] <= '0;
      end
    end else if (capture_last) begin
      for (int i = 0; i < N_INPUTS - 1; i++) begin
        frame_reg[i] <= stage_reg[i];
      end
      frame_reg[N_INPUTS-1] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_valid_reg <= 1'b0;
    end else begin
      frame_valid_reg <= capture_last;
    end
  end

  assign r0          = frame_reg[0];
  assign r1          = frame_reg[1];
  assign r2          = frame_reg[2];
  assign r3          = frame_reg[3];
  assign frame_valid = frame_valid_reg;
  assign slot        = slot_reg;

endmodule

// File: tb/tb_descheduler_block.sv
// Directed and randomized checks of descheduler_block against a queue-based frame model.
module tb_descheduler_block;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] data_in;
  logic [15:0] r0, r1, r2, r3;
  logic        frame_valid;
  logic [1:0]  slot;

  int vectors;
  int miscompares;

  // Reference model: words collected so far in the current frame, and the expected outputs.
  logic [15:0] pending [$];
  logic [15:0] exp_r [4];
  logic        exp_fv;
  int          pulses_seen;

  descheduler_block #(.DATA_WIDTH(16), .N_INPUTS(4)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .frame_valid(frame_valid), .slot(slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic rst_v, input logic en_v, input logic [15:0] d);
    exp_fv = 1'b0;
    if (!rst_v) begin
      pending.delete();
      for (int i = 0; i < 4; i++) exp_r[i] = 16'h0;
    end else if (en_v) begin
      pending.push_back(d);
      if (pending.size() == 4) begin
        for (int i = 0; i < 4; i++) exp_r[i] = pending[i];
        pending.delete();
        exp_fv = 1'b1;
      end
    end
  endtask

  task automatic step(input logic rst_v, input logic en_v, input logic [15:0] d);
    @(negedge clk);
    rst = rst_v;
    en = en_v;
    data_in = d;
    @(posedge clk);
    model_edge(rst_v, en_v, d);
    #1;
    chk("r0", 32'(r0), 32'(exp_r[0]));
    chk("r1", 32'(r1), 32'(exp_r[1]));
    chk("r2", 32'(r2), 32'(exp_r[2]));
    chk("r3", 32'(r3), 32'(exp_r[3]));
    chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
    chk("slot", 32'(slot), 32'(pending.size()));
    if (frame_valid) pulses_seen++;
    $display("step rst=%0b en=%0b din=%h -> r=%h %h %h %h fv=%0b slot=%0d",
             rst_v, en_v, d, r0, r1, r2, r3, frame_valid, slot);
  endtask

  logic [15:0] lb_words [4];

  initial begin
    vectors = 0;
    miscompares = 0;
    pulses_seen = 0;
    rst = 1'b0;
    en = 1'b1;
    data_in = 16'hFFFF;
    for (int i = 0; i < 4; i++) exp_r[i] = 16'h0;
    exp_fv = 1'b0;

    // Reset held with enable high and all-ones data.
    repeat (3) step(1'b0, 1'b1, 16'hFFFF);

    // Single frame, then hold with en low.
    step(1'b1, 1'b1, 16'h1111);
    step(1'b1, 1'b1, 16'h2222);
    step(1'b1, 1'b1, 16'h3333);
    step(1'b1, 1'b1, 16'h4444);
    repeat (3) step(1'b1, 1'b0, 16'h5555);

    // Back-to-back frames.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 16'(i));
    chk("b2b_r0", 32'(r0), 32'h0005);
    chk("b2b_r3", 32'(r3), 32'h0008);

    // Stall mid-frame.
    step(1'b1, 1'b1, 16'h00A0);
    step(1'b1, 1'b1, 16'h00A1);
    repeat (5) step(1'b1, 1'b0, 16'hDEAD);
    step(1'b1, 1'b1, 16'h00A2);
    step(1'b1, 1'b1, 16'h00A3);
    chk("stall_r2", 32'(r2), 32'h00A2);

    // Reset mid-frame.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 16'(i));
    step(1'b1, 1'b1, 16'h0077);
    step(1'b1, 1'b1, 16'h0088);
    step(1'b0, 1'b1, 16'h0099);
    chk("midrst_r0", 32'(r0), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h00B0 + 16'(i));
    chk("midrst_r1", 32'(r1), 32'h00B1);

    // Loopback: a round-robin serializer released from reset on the same edge.
    lb_words[0] = 16'h0A0A; lb_words[1] = 16'h0B0B;
    lb_words[2] = 16'h0C0C; lb_words[3] = 16'h0D0D;
    step(1'b0, 1'b1, 16'h0);
    pulses_seen = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, lb_words[k]);
      chk("loop_r0", 32'(r0), 32'h0A0A);
      chk("loop_r1", 32'(r1), 32'h0B0B);
      chk("loop_r2", 32'(r2), 32'h0C0C);
      chk("loop_r3", 32'(r3), 32'h0D0D);
    end
    chk("loop_pulses", 32'(pulses_seen), 32'd3);

    // Randomized traffic with stalls and occasional resets.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/descheduler_block.md
Name: descheduler_block

Overview:
- Receive-side counterpart of the 4-to-1 round-robin scheduler block.
- Takes the single time-multiplexed stream (one DATA_WIDTH word per clock, slot order 0,1,2,3,0,...) and rebuilds the four parallel channels r0..r3.
- Buffers a full frame of N_INPUTS words and presents all four words together, with a one-cycle frame-valid strobe.
- Sits directly downstream of the scheduler output in loopback and link testbenches.

Parameters:
- DATA_WIDTH, 16, width of each data word.
- N_INPUTS, 4, slots per frame. The block supports only 4; the port list is fixed at r0..r3.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low (0 = reset).
- en  input  1  slot-advance enable; 0 stalls the block.
- data_in  input  DATA_WIDTH  serialized word for the current slot.
- r0  output  DATA_WIDTH  channel 0 word of the last completed frame.
- r1  output  DATA_WIDTH  channel 1 word of the last completed frame.
- r2  output  DATA_WIDTH  channel 2 word of the last completed frame.
- r3  output  DATA_WIDTH  channel 3 word of the last completed frame.
- frame_valid  output  1  one-cycle pulse when r0..r3 are updated.
- slot  output  2  slot index that will capture at the next enabled edge.

Behaviour:
- Reset (rst=0 sampled on a rising edge):
  - slot=0, staging regs s0..s2=0, r0..r3=0, frame_valid=0.
  - Any partial frame is discarded.
  - Reset dominates en.
- Slot counter:
  - 2-bit, advances only on edges with rst=1 and en=1.
  - Sequence 0->1->2->3->0; wraps from 3 to 0 with no idle cycle.
  - Holds its value when en=0.
- Capture on each enabled edge:
  - slot 0, 1, 2: data_in is written to s0, s1, s2 respectively.
  - slot 3: r0<=s0, r1<=s1, r2<=s2, r3<=data_in, all on the same edge; frame_valid<=1.
  - The last word bypasses staging, so frame latency is 1 clock after the slot-3 word is presented.
- frame_valid:
  - 1 for exactly the cycle following the slot-3 capture edge; 0 on every other cycle.
  - Back-to-back frames with en=1 give one pulse every 4 cycles.
- Stall (en=0):
  - No capture, staging regs hold, outputs hold, frame_valid=0.
  - A frame may stall in mid-collection for any number of cycles and resumes at the held slot.
- Outputs r0..r3:
  - Change only on a slot-3 capture edge or on reset.
  - Otherwise they hold the last frame, so the four words are always mutually coherent.
- Alignment to the scheduler:
  - Both blocks are released from reset on the same edge with en=1.
  - The first word the scheduler emits after release lands in slot 0, so r(k) equals scheduler input r(k) for each frame.
  - Round-trip latency = scheduler latency + 4-word collection + 1 clock.
- Reset mid-frame:
  - Partial data in s0..s2 is cleared.
  - r0..r3 are cleared to 0; the previous frame is not retained.
  - Collection restarts at slot 0 on the first edge after rst=1.
- Data is passed through unmodified; no arithmetic, no width change.
- The slot output is the internal counter value, registered and glitch-free.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with data_in=16'hFFFF, en=1 -> r0..r3=0, frame_valid=0, slot=0 throughout; after release, slot counts 0,1,2,3.
- Single frame: en=1, drive data_in=16'h1111, 16'h2222, 16'h3333, 16'h4444 on 4 consecutive edges -> the next cycle shows r0=1111, r1=2222, r2=3333, r3=4444 and frame_valid=1 for exactly 1 cycle; outputs hold afterward.
- Back-to-back frames: stream 8 words 16'h0001..16'h0008 -> frame_valid pulses 4 cycles apart; second frame gives r0..r3=0005..0008; r0..r3 never show a mixed frame.
- Stall mid-frame: feed 16'hA0 and 16'hA1, drop en for 5 cycles while data_in=16'hDEAD, then feed 16'hA2 and 16'hA3 -> frame A0,A1,A2,A3; slot held at 2 during the stall; no pulse during the stall.
- Reset mid-frame: after a full frame 1..4, feed 2 words, assert rst=0 for 1 cycle, then stream 16'hB0..16'hB3 -> r0..r3=0 after reset, next frame B0..B3; the pre-reset partial words never appear.
- Loopback: scheduler_block feeding data_in, with r0..r3 inputs = 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D and common reset release -> descheduler r0..r3 match those values every frame.
